ram_sp_arbiter: RTL and testbench

- Two-channel round-robin arbiter and sequencer for the 64x8 single-port RAM (cs / wr_en / o_en, registered read, bidirectional data bus).
- Accepts independent read/write requests from two masters and serialises them onto the RAM pins.
- Owns bus turnaround. Drives the data bus only on writes, and captures read data on the second read cycle.
- Sits between the RAM and its two clients, so neither client touches the RAM pins.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 37 +++
 rtl/ram_sp_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_sp_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the single-port RAM arbiter.
//   state_t     - sequencer state encoding (IDLE / WRITE / RD_ADDR / RD_DATA)
//   ADDR_W_DEF  - default RAM address width (64 words)
//   DATA_W_DEF  - default RAM word width
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin pick.
//   clk, rst_n : clock and synchronous active-low reset
//   req[1:0]   : request per channel
//   advance    : high when the caller accepts the current grant
//   grant[1:0] : one-hot grant (combinational), zero when nothing requests
// The pointer names the channel that wins the next contention. It only moves
// when both channels were requesting, so a lone requester never disturbs it.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic pointer;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pointer <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            // Hand priority to the channel that just lost.
            pointer <= ~grant[1];
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: two-channel round-robin sequencer for a single-port RAM
// with registered read and a bidirectional data bus.
//   clk, rst_n                : clock, synchronous active-low reset
//   m0_* / m1_*               : client channels (req/we/addr/wdata in,
//                               gnt/rvalid/rdata out)
//   ram_cs/ram_wr_en/ram_o_en : RAM controls (registered)
//   ram_wr_adrs/ram_rd_adrs   : RAM addresses (registered, hold last value)
//   ram_data                  : RAM data bus, driven only during WRITE
//   state                     : current sequencer state, for observation
//
// Client handshake: a client raises req with we/addr/wdata and holds them
// until it sees gnt (a one-cycle pulse, one cycle after the accepting edge).
// Fields may change during the gnt cycle; a req still high in the following
// IDLE cycle is a new command. Read data arrives with a one-cycle rvalid
// pulse two cycles after gnt, and rdata holds until the next read completes.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_cs,
    output logic              ram_wr_en,
    output logic              ram_o_en,
    output logic [ADDR_W-1:0] ram_wr_adrs,
    output logic [ADDR_W-1:0] ram_rd_adrs,
    inout  wire  [DATA_W-1:0] ram_data,
    output state_t            state
);

    state_t            state_q, state_d;
    logic [1:0]        grant;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic              ch_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;

    assign accept   = (state_q == IDLE) && (m0_req || m1_req);
    assign sel_we   = grant[1] ? m1_we   : m0_we;
    assign sel_addr = grant[1] ? m1_addr : m0_addr;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req, m0_req}),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = sel_we ? WRITE : RD_ADDR;
            WRITE:   state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every pin-facing output is computed from the next state so that it
    // takes its value exactly during the cycle of that state. The command
    // address is not kept separately: it lives in the address outputs, which
    // hold their last value outside their own states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= 1'b0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            ram_cs      <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_o_en    <= 1'b0;
            ram_wr_adrs <= '0;
            ram_rd_adrs <= '0;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            state_q   <= state_d;
            ram_cs    <= (state_d != IDLE);
            ram_wr_en <= (state_d == WRITE);
            ram_o_en  <= (state_d == RD_DATA);
            drive_q   <= (state_d == WRITE);
            m0_gnt    <= accept && grant[0];
            m1_gnt    <= accept && grant[1];

            if (accept) begin
                ch_q    <= grant[1];
                wdata_q <= grant[1] ? m1_wdata : m0_wdata;
                if (sel_we) ram_wr_adrs <= sel_addr;
                else        ram_rd_adrs <= sel_addr;
            end

            // The RAM drives the bus for the whole RD_DATA cycle.
            m0_rvalid <= (state_q == RD_DATA) && !ch_q;
            m1_rvalid <= (state_q == RD_DATA) &&  ch_q;
            if (state_q == RD_DATA) begin
                if (ch_q) m1_rdata <= ram_data;
                else      m0_rdata <= ram_data;
            end
        end
    end

    // drive_q is only ever high in WRITE, a state that is always entered from
    // IDLE, so the bus cannot overlap with ram_o_en.
    assign ram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign state    = state_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
module tb_ram_sp_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_cs, ram_wr_en, ram_o_en;
    logic [AW-1:0] ram_wr_adrs, ram_rd_adrs;
    wire  [DW-1:0] ram_data;
    state_t        state;

    ram_sp_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_o_en(ram_o_en),
        .ram_wr_adrs(ram_wr_adrs), .ram_rd_adrs(ram_rd_adrs),
        .ram_data(ram_data), .state(state)
    );

    // ---------------- single-port RAM model ----------------
    logic [DW-1:0] mem [64];
    logic [DW-1:0] ram_q = '0;
    initial for (int i = 0; i < 64; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_cs && ram_wr_en)  mem[ram_wr_adrs] <= ram_data;
        if (ram_cs && !ram_wr_en) ram_q <= mem[ram_rd_adrs];
    end
    assign ram_data = ram_o_en ? ram_q : {DW{1'bz}};

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic          exp_gnt_q[$];
    bit            track_gnt = 0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rd_gnt_cyc[2] = '{0, 0};
    logic          prev_o_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT responses against the expected queues.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (m0_gnt || m1_gnt) begin
                check("gnt_onehot", 32'(m0_gnt & m1_gnt), 0);
                if (!ram_wr_en) rd_gnt_cyc[m1_gnt ? 1 : 0] = cyc;
                if (track_gnt) begin
                    check("gnt_expected", 32'(exp_gnt_q.size() != 0), 1);
                    if (exp_gnt_q.size() != 0) check("gnt_order", 32'(m1_gnt), 32'(exp_gnt_q.pop_front()));
                end
            end
            if (m0_rvalid) begin
                check("rv0_expected", 32'(exp_q0.size() != 0), 1);
                if (exp_q0.size() != 0) check("m0_rdata", 32'(m0_rdata), 32'(exp_q0.pop_front()));
                check("m0_rvalid_lat", 32'(cyc - rd_gnt_cyc[0]), 2);
            end
            if (m1_rvalid) begin
                check("rv1_expected", 32'(exp_q1.size() != 0), 1);
                if (exp_q1.size() != 0) check("m1_rdata", 32'(m1_rdata), 32'(exp_q1.pop_front()));
                check("m1_rvalid_lat", 32'(cyc - rd_gnt_cyc[1]), 2);
            end
            if (ram_wr_en) check("bus_turnaround", 32'({ram_o_en, prev_o_en}), 0);
            prev_o_en = ram_o_en;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit ch, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit push,
                         input logic [DW-1:0] exp_rd, input int exp_wait);
        int waited = 0;
        bit got = 0;
        if (!ch) begin m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1; end
        else     begin m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1; end
        if (!we && push) begin
            if (!ch) exp_q0.push_back(exp_rd);
            else     exp_q1.push_back(exp_rd);
        end
        while (!got && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
            got = ch ? m1_gnt : m0_gnt;
        end
        if (!ch) m0_req = 0;
        else     m1_req = 0;
        check("gnt_timeout", 32'(got), 1);
        if (exp_wait > 0) check("gnt_latency", 32'(waited), 32'(exp_wait));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_state"}, 32'(state), 32'(IDLE));
        check({name, "_ctrl"}, 32'({ram_cs, ram_wr_en, ram_o_en, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 0);
        check({name, "_rdata"}, 32'({m0_rdata, m1_rdata}), 0);
        check({name, "_adrs"}, 32'({ram_wr_adrs, ram_rd_adrs}), 0);
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        // Write 0xA5 to 5, read it back on m0.
        issue(0, 1, 6'd5, 8'hA5, 0, 8'h00, 1);
        issue(0, 0, 6'd5, 8'h00, 1, 8'hA5, 2);
        settle();

        // Simultaneous writes: m0 wins first contention after reset.
        track_gnt = 1;
        exp_gnt_q.push_back(1'b0);
        exp_gnt_q.push_back(1'b1);
        fork
            issue(0, 1, 6'd1, 8'h11, 0, 8'h00, 1);
            issue(1, 1, 6'd2, 8'h22, 0, 8'h00, 3);
        join
        settle();
        check("gnt_q_drained_2", 32'(exp_gnt_q.size()), 0);
        track_gnt = 0;
        issue(0, 0, 6'd1, 8'h00, 1, 8'h11, 1);
        issue(1, 0, 6'd2, 8'h00, 1, 8'h22, 0);
        settle();

        // Preload for the contention reads.
        for (int i = 0; i < 4; i++) issue(0, 1, AW'(30 + i), DW'(8'h30 + i), 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) issue(1, 1, AW'(40 + i), DW'(8'h40 + i), 0, 8'h00, 0);
        settle();

        // Both channels request continuously: the pointer favours m1 after
        // the earlier contention, so grants go 1,0,1,0,...
        track_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt_q.push_back(1'b1);
            exp_gnt_q.push_back(1'b0);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, 0, AW'(30 + i), 8'h00, 1, DW'(8'h30 + i), 0);
            end
            begin
                for (int j = 0; j < 4; j++) issue(1, 0, AW'(40 + j), 8'h00, 1, DW'(8'h40 + j), 0);
            end
        join
        settle();
        check("gnt_q_drained_3", 32'(exp_gnt_q.size()), 0);
        track_gnt = 0;

        // m1 alone, back-to-back writes: one grant every two cycles.
        for (int i = 0; i < 4; i++) issue(1, 1, AW'(20 + i), DW'(8'hC0 + i), 0, 8'h00, (i == 0) ? 1 : 2);
        settle();
        for (int i = 0; i < 4; i++) issue(0, 0, AW'(20 + i), 8'h00, 1, DW'(8'hC0 + i), 0);
        settle();

        // Read of the top address followed immediately by a write to 0.
        issue(0, 1, 6'd63, 8'h5A, 0, 8'h00, 1);
        issue(0, 0, 6'd63, 8'h00, 1, 8'h5A, 2);
        issue(0, 1, 6'd0, 8'h3C, 0, 8'h00, 3);
        issue(1, 0, 6'd0, 8'h00, 1, 8'h3C, 2);
        settle();

        // Reset during RD_ADDR: read aborted, rdata cleared, no rvalid.
        issue(0, 0, 6'd5, 8'h00, 0, 8'h00, 1);
        check("in_rd_addr", 32'(state), 32'(RD_ADDR));
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        check_reset_state("rst_rd");
        settle();

        // Reset during WRITE: the word is still stored.
        issue(1, 1, 6'd9, 8'h99, 0, 8'h00, 1);
        check("in_write", 32'(state), 32'(WRITE));
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        check_reset_state("rst_wr");
        issue(0, 0, 6'd9, 8'h00, 1, 8'h99, 1);
        settle();

        check("exp_q0_empty", 32'(exp_q0.size()), 0);
        check("exp_q1_empty", 32'(exp_q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
